// File: rtl/banner_line_gen.sv
// Streams ASCII banner lines (stars, rules, underscores or a box) over a
// valid/ready character interface, one command of N lines at a time.
module banner_line_gen #(
   parameter int unsigned LINE_LEN = 76,
   parameter int unsigned LINES_W  = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_style_i,
   input  logic [LINES_W-1:0] cmd_lines_i,
   output logic [7:0]         char_o,
   output logic               char_valid_o,
   input  logic               char_ready_i,
   output logic               char_last_o,
   output logic               busy_o
);

   localparam int unsigned COL_W = $clog2(LINE_LEN + 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_DASH  = 8'h2D;
   localparam logic [7:0] CH_LOW   = 8'h5F;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_PIPE  = 8'h7C;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_LF    = 8'h0A;

   typedef enum logic [1:0] {
      StIdle,
      StEmit,
      StEol
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           style_q, style_d;
   logic [LINES_W-1:0]   lines_q, lines_d;
   logic [LINES_W-1:0]   line_q, line_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic                 ready_en_q;

   logic                 xfer;
   logic                 last_line;
   logic                 border_line;
   logic                 edge_col;

   // Keeps cmd_ready_o low during reset and until the first edge after release.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         style_q <= 2'd0;
         lines_q <= '0;
         line_q  <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         style_q <= style_d;
         lines_q <= lines_d;
         line_q  <= line_d;
         col_q   <= col_d;
      end
   end

   assign cmd_ready_o  = (state_q == StIdle) && ready_en_q;
   assign char_valid_o = (state_q != StIdle);
   assign busy_o       = (state_q != StIdle);
   assign xfer         = char_valid_o && char_ready_i;

   assign last_line   = (line_q == (lines_q - LINES_W'(1)));
   assign border_line = (line_q == '0) || last_line;
   assign edge_col    = (col_q == '0) || (col_q == LAST_COL);
   assign char_last_o = (state_q == StEol) && last_line;

   always_comb begin
      state_d = state_q;
      style_d = style_q;
      lines_d = lines_q;
      line_d  = line_q;
      col_d   = col_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i && cmd_ready_o) begin
               style_d = cmd_style_i;
               lines_d = cmd_lines_i;
               line_d  = '0;
               col_d   = '0;
               if (cmd_lines_i != '0) begin
                  state_d = StEmit;
               end
            end
         end
         StEmit: begin
            if (xfer) begin
               col_d = col_q + COL_W'(1);
               if (col_q == LAST_COL) begin
                  state_d = StEol;
               end
            end
         end
         StEol: begin
            if (xfer) begin
               col_d  = '0;
               line_d = line_q + LINES_W'(1);
               state_d = last_line ? StIdle : StEmit;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      char_o = 8'h00;
      unique case (state_q)
         StEmit: begin
            case (style_q)
               2'd0: char_o = CH_STAR;
               2'd1: char_o = CH_DASH;
               2'd2: char_o = CH_LOW;
               default: begin
                  if (border_line) begin
                     char_o = edge_col ? CH_PLUS : CH_DASH;
                  end else begin
                     char_o = edge_col ? CH_PIPE : CH_SPACE;
                  end
               end
            endcase
         end
         StEol: char_o = CH_LF;
         default: char_o = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_banner_line_gen.sv
// Directed bench for banner_line_gen with LINE_LEN=76, LINES_W=4.
module tb_banner_line_gen;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [1:0] cmd_style_i;
   logic [3:0] cmd_lines_i;
   logic [7:0] char_o;
   logic       char_valid_o;
   logic       char_ready_i;
   logic       char_last_o;
   logic       busy_o;

   int checks   = 0;
   int failures = 0;

   banner_line_gen #(
      .LINE_LEN(76),
      .LINES_W (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_style_i (cmd_style_i),
      .cmd_lines_i (cmd_lines_i),
      .char_o      (char_o),
      .char_valid_o(char_valid_o),
      .char_ready_i(char_ready_i),
      .char_last_o (char_last_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [15:0] observed,
                        input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] exp_char(input int style, input int lines, input int idx);
      int line;
      int col;
      logic border;
      logic edge_c;
      line = idx / 77;
      col  = idx % 77;
      if (col == 76) return 8'h0A;
      case (style)
         0: return 8'h2A;
         1: return 8'h2D;
         2: return 8'h5F;
         default: begin
            border = (line == 0) || (line == lines - 1);
            edge_c = (col == 0) || (col == 75);
            if (border) return edge_c ? 8'h2B : 8'h2D;
            return edge_c ? 8'h7C : 8'h20;
         end
      endcase
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Offers one command at the current slot and steps through its acceptance edge.
   task automatic issue(input int style, input int lines);
      cmd_valid_i = 1'b1;
      cmd_style_i = 2'(style);
      cmd_lines_i = 4'(lines);
      check("cmd_ready_before_accept", 16'(cmd_ready_o), 16'd1);
      step();
      cmd_valid_i = 1'b0;
   endtask

   // Walks a command's stream; with stall=1 the sink alternates ready 1/0,
   // and the presented character must match the pending index throughout.
   task automatic collect(input int style, input int lines, input bit stall, input int stop_at);
      int total;
      int idx;
      int cyc;
      total = lines * 77;
      idx   = 0;
      cyc   = 0;
      while (idx < total && idx < stop_at) begin
         char_ready_i = stall ? ((cyc % 2) == 0) : 1'b1;
         check($sformatf("valid s%0d i%0d", style, idx), 16'(char_valid_o), 16'd1);
         check($sformatf("busy s%0d i%0d", style, idx), 16'(busy_o), 16'd1);
         check($sformatf("cmd_ready_busy s%0d i%0d", style, idx), 16'(cmd_ready_o), 16'd0);
         check($sformatf("char s%0d i%0d", style, idx), 16'(char_o),
               16'(exp_char(style, lines, idx)));
         check($sformatf("last s%0d i%0d", style, idx), 16'(char_last_o),
               16'(idx == total - 1));
         step();
         if (char_ready_i) idx++;
         cyc++;
         if (cyc > 2000) begin
            checks++;
            failures++;
            $display("FAIL timeout s%0d observed_idx=%0d required=%0d", style, idx, total);
            break;
         end
      end
      char_ready_i = 1'b1;
      if (stop_at >= total) begin
         check($sformatf("cycles s%0d", style), 16'(cyc), 16'(stall ? 2 * total - 1 : total));
         check("idle_valid_after", 16'(char_valid_o), 16'd0);
         check("idle_busy_after", 16'(busy_o), 16'd0);
         check("idle_ready_after", 16'(cmd_ready_o), 16'd1);
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_style_i  = 2'd0;
      cmd_lines_i  = 4'd0;
      char_ready_i = 1'b1;

      #2;
      check("rst_char", 16'(char_o), 16'h00);
      check("rst_valid", 16'(char_valid_o), 16'd0);
      check("rst_last", 16'(char_last_o), 16'd0);
      check("rst_busy", 16'(busy_o), 16'd0);
      check("rst_cmd_ready", 16'(cmd_ready_o), 16'd0);
      step();
      step();
      rst_i = 1'b0;
      check("ready_before_first_edge", 16'(cmd_ready_o), 16'd0);
      step();
      check("ready_after_release", 16'(cmd_ready_o), 16'd1);

      // Style 0, one line, no stalls.
      issue(0, 1);
      collect(0, 1, 1'b0, 9999);

      // Box of three lines.
      issue(3, 3);
      collect(3, 3, 1'b0, 9999);

      // Hrule, two lines, sink toggling.
      issue(1, 2);
      collect(1, 2, 1'b1, 9999);

      // Zero-line command.
      issue(2, 0);
      check("zero_valid", 16'(char_valid_o), 16'd0);
      check("zero_ready", 16'(cmd_ready_o), 16'd1);
      check("zero_busy", 16'(busy_o), 16'd0);
      step();
      check("zero_valid_later", 16'(char_valid_o), 16'd0);

      // Reset after ten transfers of a style 2 command.
      issue(2, 3);
      collect(2, 3, 1'b0, 10);
      rst_i = 1'b1;
      #1;
      check("mid_rst_char", 16'(char_o), 16'h00);
      check("mid_rst_valid", 16'(char_valid_o), 16'd0);
      check("mid_rst_last", 16'(char_last_o), 16'd0);
      check("mid_rst_busy", 16'(busy_o), 16'd0);
      check("mid_rst_ready", 16'(cmd_ready_o), 16'd0);
      step();
      rst_i = 1'b0;
      step();
      check("post_rst_ready", 16'(cmd_ready_o), 16'd1);
      check("post_rst_valid", 16'(char_valid_o), 16'd0);
      issue(0, 1);
      collect(0, 1, 1'b0, 9999);

      // Back-to-back commands with cmd_valid_i held high.
      cmd_valid_i = 1'b1;
      cmd_style_i = 2'd0;
      cmd_lines_i = 4'd1;
      step();
      cmd_style_i = 2'd1;
      collect(0, 1, 1'b0, 9999);
      step();
      cmd_valid_i = 1'b0;
      collect(1, 1, 1'b0, 9999);
      step();
      check("final_idle_valid", 16'(char_valid_o), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "global timeout");
   end

endmodule
